// File: rtl/toggle_pkg.sv
// Shared encodings and defaults for the toggle debouncer front end.
package toggle_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_e;

  // Debounced level is high once a press has been accepted until the release is confirmed.
  function automatic logic is_high_state(input state_e st);
    return (st == ST_PRESSED) || (st == ST_RELEASE_WAIT);
  endfunction

endpackage

// File: rtl/toggle_debouncer_sync.sv
// Two-flop synchronizer for a single asynchronous level, reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/toggle_debouncer.sv
// Debounces a raw button into a one-cycle toggle command, toggle state and press count.
module toggle_debouncer
  import toggle_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned DCNT_W          = 8,
  parameter int unsigned COUNT_W         = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_in,
  input  logic               en,
  output logic               t_pulse,
  output logic               q,
  output logic [COUNT_W-1:0] press_count,
  output logic               btn_stable
);

  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);

  logic s;

  sync_2ff u_sync_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_in),
    .q     (s)
  );

  state_e              state_q, state_d;
  logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
  logic                t_pulse_q, t_pulse_d;
  logic                q_q, q_d;
  logic [COUNT_W-1:0]  cnt_q, cnt_d;
  logic                btn_stable_q, btn_stable_d;
  logic                accept;
  logic                fire;

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    accept  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (s) begin
          state_d = ST_PRESS_WAIT;
          dcnt_d  = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!s) begin
          state_d = ST_IDLE;
        end else if (dcnt_q == DCNT_LAST) begin
          state_d = ST_PRESSED;
          accept  = 1'b1;
        end else begin
          dcnt_d = dcnt_q + DCNT_W'(1);
        end
      end
      ST_PRESSED: begin
        if (!s) begin
          state_d = ST_RELEASE_WAIT;
          dcnt_d  = '0;
        end
      end
      ST_RELEASE_WAIT: begin
        if (s) begin
          state_d = ST_PRESSED;
        end else if (dcnt_q == DCNT_LAST) begin
          state_d = ST_IDLE;
        end else begin
          dcnt_d = dcnt_q + DCNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A press accepted while disabled is consumed: the FSM still advances, only the effects are masked.
    fire         = accept & en;
    t_pulse_d    = fire;
    q_d          = q_q ^ fire;
    cnt_d        = cnt_q + COUNT_W'(fire);
    btn_stable_d = is_high_state(state_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      dcnt_q       <= '0;
      t_pulse_q    <= 1'b0;
      q_q          <= 1'b0;
      cnt_q        <= '0;
      btn_stable_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dcnt_q       <= dcnt_d;
      t_pulse_q    <= t_pulse_d;
      q_q          <= q_d;
      cnt_q        <= cnt_d;
      btn_stable_q <= btn_stable_d;
    end
  end

  assign t_pulse     = t_pulse_q;
  assign q           = q_q;
  assign press_count = cnt_q;
  assign btn_stable  = btn_stable_q;

endmodule

// File: tb/tb_toggle_debouncer.sv
// Directed and random stimulus for two debouncer instances (4-cycle and 1-cycle debounce) against a run-length model.
module tb_toggle_debouncer;

  logic       clk;
  logic       rst_n;
  logic       btn_in;
  logic       en;
  logic       t_pulse0, q0, stable0;
  logic       t_pulse1, q1, stable1;
  logic [1:0] pc0, pc1;

  int total = 0;
  int bad   = 0;

  toggle_debouncer #(.DEBOUNCE_CYCLES(4), .DCNT_W(8), .COUNT_W(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .en(en),
    .t_pulse(t_pulse0), .q(q0), .press_count(pc0), .btn_stable(stable0)
  );

  toggle_debouncer #(.DEBOUNCE_CYCLES(1), .DCNT_W(8), .COUNT_W(2)) u_dut_fast (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .en(en),
    .t_pulse(t_pulse1), .q(q1), .press_count(pc1), .btn_stable(stable1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a level flips only after DEBOUNCE_CYCLES+1 consecutive synchronized samples of the opposite value.
  int   dcyc [2] = '{4, 1};
  logic m1, m2;
  int   hi [2];
  int   lo [2];
  logic lvl [2];
  logic mq  [2];
  logic mp  [2];
  int   mc  [2];
  int   npulse;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pulse0"},  int'(t_pulse0), int'(mp[0]));
    chk({tag, ".q0"},      int'(q0),       int'(mq[0]));
    chk({tag, ".cnt0"},    int'(pc0),      mc[0]);
    chk({tag, ".stable0"}, int'(stable0),  int'(lvl[0]));
    chk({tag, ".pulse1"},  int'(t_pulse1), int'(mp[1]));
    chk({tag, ".q1"},      int'(q1),       int'(mq[1]));
    chk({tag, ".cnt1"},    int'(pc1),      mc[1]);
    chk({tag, ".stable1"}, int'(stable1),  int'(lvl[1]));
  endtask

  task automatic model_clear();
    m1 = 1'b0;
    m2 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      hi[i] = 0; lo[i] = 0; lvl[i] = 1'b0;
      mq[i] = 1'b0; mp[i] = 1'b0; mc[i] = 0;
    end
  endtask

  task automatic step(input logic b, input logic e, input string tag);
    logic s;
    btn_in = b;
    en     = e;
    @(posedge clk);
    s  = m2;
    m2 = m1;
    m1 = b;
    for (int i = 0; i < 2; i++) begin
      mp[i] = 1'b0;
      if (!lvl[i]) begin
        hi[i] = s ? hi[i] + 1 : 0;
        if (hi[i] == dcyc[i] + 1) begin
          lvl[i] = 1'b1;
          lo[i]  = 0;
          if (e) begin
            mp[i] = 1'b1;
            mq[i] = ~mq[i];
            mc[i] = (mc[i] + 1) % 4;
          end
        end
      end else begin
        lo[i] = !s ? lo[i] + 1 : 0;
        if (lo[i] == dcyc[i] + 1) begin
          lvl[i] = 1'b0;
          hi[i]  = 0;
        end
      end
    end
    #1;
    if (t_pulse0) npulse++;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_clear();
    check_all("rst_now");
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all("rst_hold");
    rst_n = 1'b1;
  endtask

  initial begin
    int wrap_exp [5] = '{1, 2, 3, 0, 1};
    int len;
    logic b, e;

    rst_n  = 1'b1;
    btn_in = 1'b0;
    en     = 1'b1;
    npulse = 0;
    #1;
    do_reset();

    // Clean press: one pulse on the 7th edge, none while held.
    npulse = 0;
    for (int k = 1; k <= 20; k++) begin
      step(1'b1, 1'b1, "clean");
      if (k == 6) chk("clean_edge6_pulse", int'(t_pulse0), 0);
      if (k == 7) chk("clean_edge7_pulse", int'(t_pulse0), 1);
    end
    chk("clean_npulse", npulse, 1);
    chk("clean_q", int'(q0), 1);
    chk("clean_stable", int'(stable0), 1);
    repeat (10) step(1'b0, 1'b1, "clean_rel");
    chk("clean_rel_stable", int'(stable0), 0);

    // Press bounce rejected by the 4-cycle instance.
    npulse = 0;
    repeat (3) step(1'b1, 1'b1, "bounce");
    step(1'b0, 1'b1, "bounce");
    repeat (3) step(1'b1, 1'b1, "bounce");
    repeat (10) step(1'b0, 1'b1, "bounce");
    chk("bounce_npulse", npulse, 0);

    // Release bounce: a short low inside a held press gives no second pulse.
    npulse = 0;
    repeat (10) step(1'b1, 1'b1, "relb");
    repeat (2)  step(1'b0, 1'b1, "relb");
    repeat (10) step(1'b1, 1'b1, "relb");
    repeat (10) step(1'b0, 1'b1, "relb");
    chk("relb_npulse", npulse, 1);

    // Enable gating: disabled press is consumed, not replayed.
    npulse = 0;
    repeat (10) step(1'b1, 1'b0, "gate_off");
    repeat (10) step(1'b0, 1'b0, "gate_off");
    repeat (5)  step(1'b0, 1'b1, "gate_idle");
    chk("gate_npulse_off", npulse, 0);
    repeat (10) step(1'b1, 1'b1, "gate_on");
    repeat (10) step(1'b0, 1'b1, "gate_on");
    chk("gate_npulse_on", npulse, 1);

    // Counter wrap at COUNT_W=2.
    do_reset();
    for (int p = 0; p < 5; p++) begin
      repeat (8) step(1'b1, 1'b1, "wrap");
      repeat (8) step(1'b0, 1'b1, "wrap");
      chk("wrap_count", int'(pc0), wrap_exp[p]);
    end

    // Reset in PRESS_WAIT with the button held: full re-debounce afterwards.
    repeat (4) step(1'b1, 1'b1, "mid");
    do_reset();
    npulse = 0;
    for (int k = 1; k <= 7; k++) step(1'b1, 1'b1, "post_rst");
    chk("post_rst_7th", int'(t_pulse0), 1);
    chk("post_rst_npulse", npulse, 1);
    repeat (10) step(1'b0, 1'b1, "post_rst_rel");

    // Random bouncing runs with random enable.
    repeat (40) begin
      len = $urandom_range(1, 9);
      b   = 1'($urandom_range(0, 1));
      e   = ($urandom_range(0, 3) != 0);
      repeat (len) step(b, e, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
